// File: rtl/mdb_wr_mux_if.sv
// rtl/mdb_wr_mux_if.sv - MDB write mux source, upstream and memory handshake bundle
interface mdb_wr_mux_if #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 4
);
    localparam int SEL_W = $clog2(NSRC);
    localparam int NLANE = WIDTH / 8;
    localparam int LSB_W = (NLANE > 1) ? $clog2(NLANE) : 1;

    logic [NSRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]      src_sel;
    logic                  bw;
    logic [LSB_W-1:0]      addr_lsb;
    logic                  up_valid;
    logic                  up_ready;
    logic [WIDTH-1:0]      mdb_data;
    logic [NLANE-1:0]      mdb_be;
    logic                  mem_valid;
    logic                  mem_ready;

    modport master (
        output src_data, src_sel, bw, addr_lsb, up_valid, mem_ready,
        input  up_ready, mdb_data, mdb_be, mem_valid
    );

    modport slave (
        input  src_data, src_sel, bw, addr_lsb, up_valid, mem_ready,
        output up_ready, mdb_data, mdb_be, mem_valid
    );
endinterface

// File: rtl/mdb_wr_mux.sv
// rtl/mdb_wr_mux.sv - registered MDB write source selector with skid buffer (option: MDB_MUX_BYTE_LANE_EN)
module mdb_wr_mux #(
    parameter int WIDTH   = 16,
    parameter int NSRC    = 4,
    parameter int DEF_SRC = 1
) (
    input logic         clk,
    input logic         rst,
    mdb_wr_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NSRC);
    localparam int NLANE = WIDTH / 8;
    localparam int LSB_W = (NLANE > 1) ? $clog2(NLANE) : 1;

    localparam logic [SEL_W:0]   NSRC_W  = (SEL_W + 1)'(NSRC);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEF_SRC);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] out_data_q;
    logic [NLANE-1:0] out_be_q;
    logic [WIDTH-1:0] skd_data_q;
    logic [NLANE-1:0] skd_be_q;
    logic             mem_valid_q;
    logic             up_ready_q;

    logic [SEL_W-1:0] sel_eff;
    logic [WIDTH-1:0] src_word;
    logic [WIDTH-1:0] new_data;
    logic [NLANE-1:0] new_be;
    logic             acc;
    logic             drn;

    assign acc = bus.up_valid & up_ready_q;
    assign drn = mem_valid_q & bus.mem_ready;

    // Pick the source and shape it into lane data and byte enables for the beat being offered
    always_comb begin
        sel_eff = DEF_SEL;
        if ({1'b0, bus.src_sel} < NSRC_W) begin
            sel_eff = bus.src_sel;
        end
        src_word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_eff == SEL_W'(i)) begin
                src_word = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
        new_data = src_word;
        new_be   = '1;
`ifdef MDB_MUX_BYTE_LANE_EN
        if (bus.bw) begin
            new_data = {NLANE{src_word[7:0]}};
            for (int l = 0; l < NLANE; l++) begin
                new_be[l] = (bus.addr_lsb == LSB_W'(l));
            end
        end
`endif
    end

`ifndef MDB_MUX_BYTE_LANE_EN
    // Word-only build: byte controls stay on the port list but have no effect
    logic unused_byte_ctl;
    assign unused_byte_ctl = &{1'b0, bus.bw, bus.addr_lsb};
`endif

    // Two-entry FIFO control: OUT feeds memory, SKD catches the beat accepted while OUT is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            out_be_q    <= '0;
            skd_data_q  <= '0;
            skd_be_q    <= '0;
            mem_valid_q <= 1'b0;
            up_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        out_data_q  <= new_data;
                        out_be_q    <= new_be;
                        state_q     <= ST_ONE;
                        mem_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        out_data_q <= new_data;
                        out_be_q   <= new_be;
                    end else if (acc) begin
                        skd_data_q <= new_data;
                        skd_be_q   <= new_be;
                        state_q    <= ST_FULL;
                        up_ready_q <= 1'b0;
                    end else if (drn) begin
                        state_q     <= ST_EMPTY;
                        mem_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (drn) begin
                        out_data_q <= skd_data_q;
                        out_be_q   <= skd_be_q;
                        state_q    <= ST_ONE;
                        up_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    mem_valid_q <= 1'b0;
                    up_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.up_ready  = up_ready_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mdb_data  = out_data_q;
    assign bus.mdb_be    = out_be_q;
endmodule

// File: doc/mdb_wr_mux.md
# mdb_wr_mux

Parametrised, registered source selector for the memory data bus (MDB) write path. It selects one of `NSRC` data sources: ALU result, MDB readback, source-operand register, immediate, and so on. It forms byte-lane data and byte enables for byte/word operations and presents the result to memory through a valid/ready handshake. A one-entry skid buffer absorbs memory back-pressure, so the execute stage sees a registered `up_ready` with no combinational path from `mem_ready`.

## Interface
- `WIDTH`, 16: data width in bits; must be a multiple of 8, ≥16.
- `NSRC`, 4: number of source inputs, ≥2.
- `DEF_SRC`, 1: source used when `src_sel` ≥ `NSRC` (MDB readback slot).
- Derived, not overridable: `SEL_W` = clog2(`NSRC`), `NLANE` = `WIDTH`/8, `LSB_W` = max(1, clog2(`NLANE`)).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `src_data`  in  `NSRC`*`WIDTH`: packed sources; source i occupies bits [i*`WIDTH` +: `WIDTH`].
- `src_sel`  in  `SEL_W`: source select.
- `bw`  in  1: 1 = byte operation, 0 = word operation.
- `addr_lsb`  in  `LSB_W`: low address bits, used for byte-lane selection.
- `up_valid`  in  1: upstream write request.
- `up_ready`  out  1: request accepted this cycle when high together with `up_valid`.
- `mdb_data`  out  `WIDTH`: write data to memory.
- `mdb_be`  out  `NLANE`: byte enables.
- `mem_valid`  out  1: `mdb_data`/`mdb_be` valid.
- `mem_ready`  in  1: memory accepts the beat when high together with `mem_valid`.

## Operation
- Selection: `sel_eff` = `src_sel` if `src_sel` < `NSRC`, else `DEF_SRC`.
- Word op (`bw`=0): data = source; `be` = all ones. `addr_lsb` is ignored.
- Byte op (`bw`=1): low byte of the source is replicated to every lane; `be` is one-hot at lane `addr_lsb`.
- Data and `be` are formed combinationally at acceptance and captured in the output register (OUT) or skid register (SKD).
- FSM states:
  - EMPTY: `mem_valid`=0, `up_ready`=1.
  - ONE: OUT valid, `mem_valid`=1, `up_ready`=1.
  - FULL: OUT and SKD valid, `mem_valid`=1, `up_ready`=0.
- Transitions (acc = `up_valid`&`up_ready`, drn = `mem_valid`&`mem_ready`):
  - EMPTY: acc → ONE, OUT ← new.
  - ONE: acc & drn → ONE, OUT ← new. acc & !drn → FULL, SKD ← new. !acc & drn → EMPTY. Otherwise hold.
  - FULL: drn → ONE, OUT ← SKD. Otherwise hold.
- Order is strictly FIFO; no beat is dropped or duplicated.
- `up_ready` = (state != FULL), taken directly from the state register.
- Reset, asynchronous at any time including mid-transfer:
  - State → EMPTY; OUT and SKD data and `be` → 0.
  - `mem_valid`=0, `mdb_data`=0, `mdb_be`=0, `up_ready`=1.
  - Pending beats are discarded.

## Timing
- Latency: acceptance at edge N gives `mem_valid`=1 with that beat's data from edge N onward; one cycle from request to memory.
- Throughput: one beat per cycle while `mem_ready`=1.
- `mem_ready` low for k cycles holds OUT stable. After one further accept, `up_ready` drops in the following cycle.
- Output data, `be` and `mem_valid` change only on `clk` edges or `rst`; there are no combinational input-to-output paths.
- Inputs other than `up_valid` are sampled only when acc=1.

## Configuration
- `MDB_MUX_BYTE_LANE_EN` defined: byte-lane logic as described above.
- Undefined: `bw` and `addr_lsb` are ignored; every beat is treated as a word op (`be` all ones, full source data). Port list is unchanged.

## Test plan
All scenarios use `WIDTH`=16, `NSRC`=4, `DEF_SRC`=1, macro defined.
- Reset: assert `rst` mid-FULL → immediately `mem_valid`=0, `mdb_data`=0, `mdb_be`=0, `up_ready`=1. After release, the first accept works normally.
- Word select: src2=0xBEEF, `src_sel`=2, `bw`=0, `mem_ready`=1 → next cycle `mdb_data`=0xBEEF, `mdb_be`=2'b11.
- Byte lanes: src0=0x12A5, `bw`=1:
  - `addr_lsb`=1 → `mdb_data`=0xA5A5, `mdb_be`=2'b10.
  - `addr_lsb`=0 → `mdb_be`=2'b01.
- Out-of-range select: `NSRC`=3, `src_sel`=3, src1=0x5555 → `mdb_data`=0x5555.
- Back-pressure: `mem_ready`=0, send beats 0x0001 and 0x0002 → `up_ready`=0 after the second; 0x0003 is held upstream. Raise `mem_ready` → memory sees 0x0001, 0x0002, 0x0003 in order, with no gaps once ready.
- Streaming: 8 back-to-back beats with `mem_ready`=1 → 8 consecutive `mem_valid` cycles and `up_ready` never drops.
